// File: rtl/skip_pack_pkg.sv
// Shared constants and width helpers for the skip-stream packer.
// Defining SKIP_PACK_TIMESTAMP_EN adds a 32-bit timestamp to every stored word.
package skip_pack_pkg;

  localparam int LANES_PER_GROUP        = 4;
  localparam int GROUPS_PER_WORD        = 2;
  localparam int LANES_PER_WORD         = LANES_PER_GROUP * GROUPS_PER_WORD;
  localparam int DEFAULT_FIFO_DEPTH_LOG2 = 2;

`ifdef SKIP_PACK_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif

  function automatic int word_w(input int nof_bits);
    return LANES_PER_WORD * nof_bits + TS_W;
  endfunction

  // FIFO entry = sample word (+ timestamp) plus one trigger bit per lane.
  function automatic int fifo_w(input int nof_bits);
    return word_w(nof_bits) + LANES_PER_WORD;
  endfunction

endpackage

// File: rtl/skip_pack_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Output reads as zero while empty so the downstream bus is quiet.
module skip_pack_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = rd_en && !empty;
  // A write into a full FIFO still lands when the head leaves in the same cycle.
  assign push  = wr_en && (!full || pop);
  assign level = count;
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/skip_data_packer.sv
// Packs pairs of 4-lane sample groups into 8-lane words, buffers them in a FWFT FIFO.
// Optional SKIP_PACK_TIMESTAMP_EN stores a cycle-count timestamp with each word.
module skip_data_packer
  import skip_pack_pkg::*;
#(
  parameter int NofBits       = 16,
  parameter int FifoDepthLog2 = DEFAULT_FIFO_DEPTH_LOG2
) (
  input  logic                              clk,
  input  logic                              rst_i,
  input  logic signed [NofBits-1:0]         x0_i,
  input  logic signed [NofBits-1:0]         x0z_i,
  input  logic signed [NofBits-1:0]         x1_i,
  input  logic signed [NofBits-1:0]         x1z_i,
  input  logic                              data_valid_i,
  input  logic                              active_i,
  input  logic [3:0]                        trigger_vector_i,
  input  logic                              ready_i,
  output logic                              valid_o,
  output logic [LANES_PER_WORD*NofBits-1:0] data_o,
  output logic [7:0]                        trig_o,
  output logic [31:0]                       ts_o,
  output logic                              overflow_o,
  output logic [FifoDepthLog2:0]            level_o
);

  localparam int HALF_W = LANES_PER_GROUP * NofBits;
  localparam int WORD_W = LANES_PER_WORD * NofBits;
  localparam int FIFO_W = fifo_w(NofBits);

  logic [HALF_W-1:0] grp_data;
  logic              active_q;
  logic              half;
  logic              flush;
  logic              word_done;
  logic [HALF_W-1:0] lo_data;
  logic [3:0]        lo_trig;
  logic [WORD_W-1:0] word_p0;
  logic [7:0]        trig_p0;
  logic              vld_p0;
  logic [FIFO_W-1:0] fifo_din;
  logic [FIFO_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign grp_data  = {x1z_i, x1_i, x0z_i, x0_i};
  // A falling active edge closes a half word only if no group arrives to finish it.
  assign flush     = active_q && !active_i && half && !data_valid_i;
  assign word_done = (data_valid_i && half) || flush;
  assign pop       = valid_o && ready_i;

  // Stage 0: assemble the word and register it for the FIFO write.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      half     <= 1'b0;
      lo_data  <= '0;
      lo_trig  <= '0;
      word_p0  <= '0;
      trig_p0  <= '0;
      vld_p0   <= 1'b0;
    end else begin
      active_q <= active_i;
      vld_p0   <= word_done;
      if (data_valid_i && !half) begin
        lo_data <= grp_data;
        lo_trig <= trigger_vector_i;
        half    <= 1'b1;
      end else if (data_valid_i) begin
        word_p0 <= {grp_data, lo_data};
        trig_p0 <= {trigger_vector_i, lo_trig};
        half    <= 1'b0;
      end else if (flush) begin
        word_p0 <= {{HALF_W{1'b0}}, lo_data};
        trig_p0 <= {4'b0000, lo_trig};
        half    <= 1'b0;
      end
    end
  end

`ifdef SKIP_PACK_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] lo_ts;
  logic [31:0] ts_p0;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ts_cnt <= '0;
      lo_ts  <= '0;
      ts_p0  <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (data_valid_i && !half) lo_ts <= ts_cnt;
      if (word_done)             ts_p0 <= lo_ts;
    end
  end

  assign fifo_din = {ts_p0, trig_p0, word_p0};
  assign ts_o     = fifo_dout[WORD_W+8 +: 32];
`else
  assign fifo_din = {trig_p0, word_p0};
  assign ts_o     = '0;
`endif

  // Stage 1: FIFO write; a word that finds no room is dropped and flagged.
  skip_pack_fifo #(
    .WIDTH (FIFO_W),
    .AW    (FifoDepthLog2)
  ) u_fifo (
    .clk   (clk),
    .rst_i (rst_i),
    .wr_en (vld_p0),
    .din   (fifo_din),
    .rd_en (ready_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
    end else if (vld_p0 && fifo_full && !pop) begin
      overflow_o <= 1'b1;
    end
  end

  assign valid_o = !fifo_empty;
  assign data_o  = fifo_dout[WORD_W-1:0];
  assign trig_o  = fifo_dout[WORD_W +: 8];

endmodule

// File: tb/tb_skip_data_packer.sv
// Scoreboard bench for skip_data_packer: lane-queue reference model plus directed and random traffic.
module tb_skip_data_packer;

  localparam int NB    = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic signed [NB-1:0] x0_i, x0z_i, x1_i, x1z_i;
  logic                 data_valid_i;
  logic                 active_i;
  logic [3:0]           trigger_vector_i;
  logic                 ready_i;
  logic                 valid_o;
  logic [8*NB-1:0]      data_o;
  logic [7:0]           trig_o;
  logic [31:0]          ts_o;
  logic                 overflow_o;
  logic [AW:0]          level_o;

  skip_data_packer #(
    .NofBits       (NB),
    .FifoDepthLog2 (AW)
  ) dut (
    .clk              (clk),
    .rst_i            (rst_i),
    .x0_i             (x0_i),
    .x0z_i            (x0z_i),
    .x1_i             (x1_i),
    .x1z_i            (x1z_i),
    .data_valid_i     (data_valid_i),
    .active_i         (active_i),
    .trigger_vector_i (trigger_vector_i),
    .ready_i          (ready_i),
    .valid_o          (valid_o),
    .data_o           (data_o),
    .trig_o           (trig_o),
    .ts_o             (ts_o),
    .overflow_o       (overflow_o),
    .level_o          (level_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8*NB-1:0] d;
    logic [7:0]      t;
  } word_t;

  word_t       exp_q[$];
  logic [NB-1:0] pend_q[$];
  logic [3:0]  pend_t;
  word_t       pipe;
  bit          pipe_v;
  bit          act_prev;
  bit          exp_ovf;
  int          checks   = 0;
  int          failures = 0;
  int          sz;
  bit          pop;
  word_t       w;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: lanes accumulate in a queue; eight lanes (or a flushed four) make a word,
  // which reaches the FIFO one cycle later and is kept only if there is room or the head leaves.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      pend_q.delete();
      pipe_v   = 1'b0;
      act_prev = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      sz = exp_q.size();
      check("valid", 128'(valid_o), 128'(sz != 0));
      check("level", 128'(level_o), 128'(sz));
      check("overflow", 128'(overflow_o), 128'(exp_ovf));
      pop = (sz != 0) && ready_i;
      if (pop) begin
        w = exp_q.pop_front();
        check("data", data_o, w.d);
        check("trig", 128'(trig_o), 128'(w.t));
`ifndef SKIP_PACK_TIMESTAMP_EN
        check("ts", 128'(ts_o), 128'(0));
`endif
      end
      if (pipe_v) begin
        if (sz < DEPTH || pop) exp_q.push_back(pipe);
        else                   exp_ovf = 1'b1;
        pipe_v = 1'b0;
      end
      if (data_valid_i) begin
        if (pend_q.size() == 0) begin
          pend_q.push_back(x0_i);
          pend_q.push_back(x0z_i);
          pend_q.push_back(x1_i);
          pend_q.push_back(x1z_i);
          pend_t = trigger_vector_i;
        end else begin
          pipe.d = {x1z_i, x1_i, x0z_i, x0_i, pend_q[3], pend_q[2], pend_q[1], pend_q[0]};
          pipe.t = {trigger_vector_i, pend_t};
          pipe_v = 1'b1;
          pend_q.delete();
        end
      end else if (act_prev && !active_i && pend_q.size() != 0) begin
        pipe.d = {{4*NB{1'b0}}, pend_q[3], pend_q[2], pend_q[1], pend_q[0]};
        pipe.t = {4'h0, pend_t};
        pipe_v = 1'b1;
        pend_q.delete();
      end
      act_prev = active_i;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(input logic [NB-1:0] a, input logic [NB-1:0] b,
                           input logic [NB-1:0] c, input logic [NB-1:0] d,
                           input logic [3:0] t);
    data_valid_i     = 1'b1;
    x0_i             = a;
    x0z_i            = b;
    x1_i             = c;
    x1z_i            = d;
    trigger_vector_i = t;
  endtask

  task automatic rnd_group();
    set_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 128'(valid_o), 128'(0));
    check({tag, "_data"}, data_o, 128'(0));
    check({tag, "_trig"}, 128'(trig_o), 128'(0));
    check({tag, "_ts"}, 128'(ts_o), 128'(0));
    check({tag, "_ovf"}, 128'(overflow_o), 128'(0));
    check({tag, "_level"}, 128'(level_o), 128'(0));
  endtask

  initial begin
    rst_i            = 1'b1;
    data_valid_i     = 1'b0;
    active_i         = 1'b0;
    ready_i          = 1'b1;
    x0_i             = '0;
    x0z_i            = '0;
    x1_i             = '0;
    x1z_i            = '0;
    trigger_vector_i = '0;
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst_i = 1'b0;

    // Two groups three cycles apart form one word visible for exactly one cycle.
    step();
    active_i = 1'b1;
    step();
    step();
    set_group(16'd1, 16'd2, 16'd3, 16'd4, 4'b0001);
    step();
    data_valid_i = 1'b0;
    step();
    step();
    set_group(16'd5, 16'd6, 16'd7, 16'd8, 4'b1000);
    step();
    data_valid_i = 1'b0;
    step();
    #3;
    check("t1_valid", 128'(valid_o), 128'(1));
    check("t1_data", data_o, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check("t1_trig", 128'(trig_o), 128'h81);
    step();
    #3;
    check("t1_valid_after", 128'(valid_o), 128'(0));

    // Half word flushed by the falling active edge, extreme sample values.
    step();
    set_group(16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 4'hF);
    step();
    data_valid_i = 1'b0;
    active_i     = 1'b0;
    step();
    step();
    #3;
    check("flush_valid", 128'(valid_o), 128'(1));
    check("flush_data", data_o, {64'h0, 64'hFFFF_0001_8000_7FFF});
    check("flush_trig", 128'(trig_o), 128'h0F);

    // Ten groups with no reader: four words stored, fifth dropped, flag sticks.
    step();
    active_i = 1'b1;
    ready_i  = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      rnd_group();
      step();
    end
    data_valid_i = 1'b0;
    repeat (4) step();
    #3;
    check("ovf_level", 128'(level_o), 128'(4));
    check("ovf_flag", 128'(overflow_o), 128'(1));
    ready_i = 1'b1;
    repeat (8) step();
    #3;
    check("ovf_drained_level", 128'(level_o), 128'(0));
    check("ovf_sticky", 128'(overflow_o), 128'(1));

    // Asynchronous reset with words queued and a half word pending.
    step();
    ready_i = 1'b0;
    rnd_group();
    step();
    rnd_group();
    step();
    rnd_group();
    step();
    data_valid_i = 1'b0;
    repeat (3) step();
    #2 rst_i = 1'b1;
    #1;
    check_all_zero("async_rst");
    #4 rst_i = 1'b0;
    ready_i = 1'b1;
    step();
    rnd_group();
    step();
    data_valid_i = 1'b0;
    step();
    rnd_group();
    step();
    data_valid_i = 1'b0;
    repeat (5) step();

    // Full FIFO written in the same cycle as a pop: nothing is lost.
    ready_i = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      rnd_group();
      step();
    end
    data_valid_i = 1'b0;
    repeat (4) step();
    #3;
    check("full_level", 128'(level_o), 128'(4));
    step();
    rnd_group();
    step();
    rnd_group();
    step();
    data_valid_i = 1'b0;
    ready_i      = 1'b1;
    step();
    ready_i = 1'b0;
    #3;
    check("full_pop_level", 128'(level_o), 128'(4));
    check("full_pop_ovf", 128'(overflow_o), 128'(0));
    ready_i = 1'b1;
    repeat (8) step();

    // Random traffic: a mostly-ready phase, then a congested phase.
    for (int i = 0; i < 1500; i++) begin
      rnd_group();
      data_valid_i = ($urandom_range(0, 2) != 0);
      ready_i      = ($urandom_range(0, 3) != 0);
      active_i     = ($urandom_range(0, 19) != 0);
      step();
    end
    for (int i = 0; i < 1500; i++) begin
      rnd_group();
      data_valid_i = ($urandom_range(0, 2) != 0);
      ready_i      = ($urandom_range(0, 3) == 0);
      active_i     = ($urandom_range(0, 19) != 0);
      step();
    end
    data_valid_i = 1'b0;
    active_i     = 1'b1;
    ready_i      = 1'b1;
    repeat (20) step();
    check("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/skip_data_packer.md
Name: skip_data_packer

Overview:
- Receive-side consumer of the sample-skip stream: takes 4-lane groups qualified by data_valid and packs two consecutive groups into one 8-sample word.
- Buffers words in a small first-word-fall-through FIFO and presents them on a valid/ready interface toward the capture/DMA writer.
- Carries per-sample trigger bits alongside the data.
- Flushes a half-filled word when acquisition ends.

Parameters:
- NofBits, 16, AD sample width in bits.
- FifoDepthLog2, 2, log2 of FIFO depth in words (default 4 words).

Ports:
- clk  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- x0_i  in  NofBits  signed lane 0 sample
- x0z_i  in  NofBits  signed lane 1 sample
- x1_i  in  NofBits  signed lane 2 sample
- x1z_i  in  NofBits  signed lane 3 sample
- data_valid_i  in  1  qualifies the four lanes this cycle
- active_i  in  1  acquisition active; the 1->0 edge triggers a flush
- trigger_vector_i  in  4  per-lane trigger flags; bit k belongs to lane k
- ready_i  in  1  downstream accepts data_o this cycle
- valid_o  out  1  data_o/trig_o hold a word
- data_o  out  8*NofBits  packed word; lane 0 of the first group sits in the LSBs
- trig_o  out  8  trigger flags aligned to data_o lanes
- ts_o  out  32  word timestamp (see Optional Feature)
- overflow_o  out  1  sticky drop flag
- level_o  out  FifoDepthLog2+1  FIFO occupancy

Behaviour:
- Reset (async, rst_i=1): half=0, assembly register=0, FIFO empty, valid_o=0, data_o=0, trig_o=0, ts_o=0, overflow_o=0, level_o=0, active history=0.
- Assembly:
  - data_valid_i with half=0: store lanes into word bits [4*NofBits-1:0] and trigger bits [3:0]; set half=1.
  - data_valid_i with half=1: store into the upper half; word is complete; set half=0.
- Flush: active_i was 1 last cycle and is 0 now, with half=1 (and no data_valid_i this cycle) -> word complete with upper half and upper trig bits zero; half=0.
- Flush with simultaneous data_valid_i: that group completes the word normally; no extra flush word.
- Latency: a word completed in cycle N is registered at the end of N, written to the FIFO at the end of N+1, and valid_o=1 in N+2 (FIFO was empty).
- FIFO is FWFT: valid_o = not empty; pop when valid_o and ready_i; data_o/trig_o/ts_o hold steady while valid_o=1 and ready_i=0.
- Write when full:
  - Accepted if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow_o=1, sticky until reset.
  - The assembly path is never stalled.
- Simultaneous push and pop with FIFO empty: push proceeds; no pop occurs since valid_o=0.
- level_o updates one cycle after a push or pop; range 0..2^FifoDepthLog2.
- Reset mid-word discards the partial half without producing a flush word.

Optional Feature:
- SKIP_PACK_TIMESTAMP_EN defined:
  - 32-bit free-running cycle counter, reset to 0, wraps 0xFFFFFFFF -> 0.
  - Counter value is captured when the first group of a word arrives (or when a flush word's only group arrives).
  - Stored in the FIFO with the word and driven on ts_o.
- Undefined: no counter; no FIFO storage for timestamps; ts_o tied to 0.

Decomposition:
- Shared package (skip_pack_pkg):
  - LANES_PER_GROUP=4, GROUPS_PER_WORD=2, LANES_PER_WORD=8.
  - Default FIFO depth.
  - Word width function 8*NofBits (+32 with timestamp).
- One sub-module, skip_pack_fifo:
  - Parameterised-width synchronous FWFT FIFO with full/empty/level.
  - Instantiated once; the top holds assembly, flush and overflow logic.

Test Plan:
- Two groups with data_valid_i in cycles 10 and 13, lanes 1..4 then 5..8, trig 0001 then 1000, ready_i=1 -> valid_o=1 in cycle 15 only, data_o lanes 1..8, trig_o=0x81.
- One group, lanes 0x7FFF,0x8000,1,-1, data_valid_i in cycle 5, active_i falls in cycle 6 -> one word with upper four lanes 0, trig_o[7:4]=0; half=0 afterwards.
- ready_i=0, 10 groups back-to-back (5 words) -> level_o=4, 5th word dropped, overflow_o=1 and stays 1 after draining; the 4 words drained in order.
- FIFO full with ready_i=1 in the same cycle a 5th word is written -> no drop, overflow_o=0, level_o stays 4.
- rst_i pulsed asynchronously between the two groups of a word -> all outputs 0 immediately; the next two groups form a clean word with no stale lanes.
- With SKIP_PACK_TIMESTAMP_EN: first group in cycle 100 after reset -> ts_o=100; counter preset near 0xFFFFFFFF wraps to 0 on the next word.
